key_event_gen: RTL and testbench



---
 rtl/key_pkg.sv | 21 ++
 rtl/key_debounce.sv | 166 ++++++++++++++++
 rtl/key_event_gen.sv | 42 ++++
 tb/tb_key_event_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared types and default constants for the push-button conditioner.
//   key_state_e           : per-key debounce FSM state
//   CLK_HZ                : system clock frequency
//   DEFAULT_DEBOUNCE      : 10 ms stability window at CLK_HZ
//   DEFAULT_REPEAT_DELAY  : hold time before the first auto-repeat (0.5 s)
//   DEFAULT_REPEAT_PERIOD : spacing of later auto-repeats (0.125 s)
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int CLK_HZ                = 50000000;
  localparam int DEFAULT_DEBOUNCE      = CLK_HZ / 100;
  localparam int DEFAULT_REPEAT_DELAY  = CLK_HZ / 2;
  localparam int DEFAULT_REPEAT_PERIOD = CLK_HZ / 8;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one push-button channel.
//   Two-flop synchronizer, debounce FSM with stability counter, registered
//   level and one-cycle press/release pulses.
//   Optional auto-repeat of the press pulse while held: `define KEY_AUTOREPEAT_EN.
// Ports:
//   i_clk            : system clock
//   i_rst            : synchronous active-high reset
//   i_key_n          : raw key, active-low, asynchronous
//   o_pressed        : debounced level, 1 = held
//   o_press_pulse    : one cycle per accepted press (and per repeat)
//   o_release_pulse  : one cycle per accepted release
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam int MAX_CNT = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                           ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD) :
                           ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam int CW = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Synchronizer holds the raw (active-low) level; reset loads "released".
  logic       r_sync1, r_sync2;
  logic       w_s;

  key_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic       r_pressed, w_pressed_nxt;
  logic       r_press_pulse, r_release_pulse;
  logic       w_press, w_release;

  assign w_s = ~r_sync2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pressed_nxt = r_pressed;
    w_press       = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt   = HELD;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b1;
          w_press       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b0;
          w_release     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  // r_rfirst selects the initial delay vs. the steady repeat period.
  // Counter only runs on cycles that stay in HELD; anything else re-arms it.
  logic [CW-1:0] r_rcnt, w_rcnt_nxt;
  logic          r_rfirst, w_rfirst_nxt;
  logic          w_repeat;

  always_comb begin
    w_rcnt_nxt   = '0;
    w_rfirst_nxt = 1'b1;
    w_repeat     = 1'b0;
    if (r_state == HELD && w_s) begin
      if (r_rcnt == (r_rfirst ? RD_LAST : RP_LAST)) begin
        w_repeat     = 1'b1;
        w_rfirst_nxt = 1'b0;
      end else begin
        w_rcnt_nxt   = r_rcnt + CW'(1);
        w_rfirst_nxt = r_rfirst;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else begin
      r_rcnt   <= w_rcnt_nxt;
      r_rfirst <= w_rfirst_nxt;
    end
  end
`else
  logic w_repeat;
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_pressed       <= w_pressed_nxt;
      r_press_pulse   <= w_press | w_repeat;
      r_release_pulse <= w_release;
    end
  end

  assign o_pressed       = r_pressed;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: conditions NUM_KEYS raw active-low push-buttons into clean
// per-key level and click-event pulses. Keys are fully independent.
// Optional auto-repeat of PRESS_PULSE while held: `define KEY_AUTOREPEAT_EN.
// Ports:
//   CLOCK_50      : system clock (50 MHz)
//   RESET         : synchronous active-high reset
//   KEY           : raw buttons, active-low, asynchronous
//   PRESSED       : debounced level per key, 1 = held
//   PRESS_PULSE   : one-cycle pulse per accepted press (and repeat)
//   RELEASE_PULSE : one-cycle pulse per accepted release
module key_event_gen
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] PRESSED,
  output logic [NUM_KEYS-1:0] PRESS_PULSE,
  output logic [NUM_KEYS-1:0] RELEASE_PULSE
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key (
      .i_clk           (CLOCK_50),
      .i_rst           (RESET),
      .i_key_n         (KEY[g]),
      .o_pressed       (PRESSED[g]),
      .o_press_pulse   (PRESS_PULSE[g]),
      .o_release_pulse (RELEASE_PULSE[g])
    );
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=4.
// Model: per key, a new sampled level is accepted once it has differed from the
// accepted level for DEBOUNCE_CYCLES+1 consecutive FSM samples; repeat pulses
// are scheduled from the number of cycles continuously held since acceptance.
module tb_key_event_gen;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key;
  logic [2:0] pressed, ppulse, rpulse;

  int total = 0;
  int bad   = 0;

  key_event_gen #(
    .NUM_KEYS(3), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .KEY(key),
    .PRESSED(pressed), .PRESS_PULSE(ppulse), .RELEASE_PULSE(rpulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] m_k1 = 3'b111, m_k2 = 3'b111;   // raw key two samples back
  logic [2:0] m_lvl = 3'b000, m_ep = 3'b000, m_er = 3'b000;
  int         m_run [3] = '{0, 0, 0};
  int         m_age [3] = '{0, 0, 0};

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_k1 = 3'b111; m_k2 = 3'b111;
      m_lvl = 3'b000; m_ep = 3'b000; m_er = 3'b000;
      for (int k = 0; k < 3; k++) begin m_run[k] = 0; m_age[k] = 0; end
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic s;
        s = ~m_k2[k];
        m_ep[k] = 1'b0;
        m_er[k] = 1'b0;
        if (s == m_lvl[k]) begin
          if (m_lvl[k] && m_run[k] == 0) begin
            m_age[k]++;
            if (AR && (m_age[k] == RD || (m_age[k] > RD && (m_age[k] - RD) % RP == 0)))
              m_ep[k] = 1'b1;
          end else begin
            m_age[k] = 0;
          end
          m_run[k] = 0;
        end else begin
          m_age[k] = 0;
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = s;
            m_run[k] = 0;
            if (s) m_ep[k] = 1'b1; else m_er[k] = 1'b1;
          end
        end
      end
      m_k2 = m_k1;
      m_k1 = key;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("pressed", pressed, m_lvl);
    chk("press_pulse", ppulse, m_ep);
    chk("release_pulse", rpulse, m_er);
  end

  // ---------------- directed stimulus ----------------
  int pp1_cnt;
  int pp0_cnt;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (ppulse[1]) pp1_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    key = 3'b000;
    pp1_cnt = 0;
    // 1. reset with all keys held
    cyc(3);
    chk("rst_pressed", pressed, 3'b000);
    chk("rst_pulse", ppulse, 3'b000);
    rst = 1'b0;
    cyc(6);
    chk("t1_before", ppulse, 3'b000);
    cyc(1);
    chk("t1_pulse", ppulse, 3'b111);
    chk("t1_pressed", pressed, 3'b111);
    cyc(1);
    chk("t1_pulse_end", ppulse, 3'b000);
    chk("t1_pressed_hold", pressed, 3'b111);
    key = 3'b111;
    cyc(12);
    chk("t1_released", pressed, 3'b000);

    // 2. clean click on key 0
    key = 3'b110;
    cyc(6);
    chk("t2_before", ppulse, 3'b000);
    cyc(1);
    chk("t2_pulse", ppulse, 3'b001);
    chk("t2_pressed", pressed, 3'b001);
    cyc(13);
    key = 3'b111;
    cyc(6);
    chk("t2_rel_before", rpulse, 3'b000);
    cyc(1);
    chk("t2_rel_pulse", rpulse, 3'b001);
    chk("t2_rel_pressed", pressed, 3'b000);
    cyc(1);
    chk("t2_rel_end", rpulse, 3'b000);
    cyc(4);

    // 3. bounce on key 1
    pp1_cnt = 0;
    key = 3'b101; cyc(3);
    key = 3'b111; cyc(1);
    key = 3'b101; cyc(2);
    key = 3'b111; cyc(1);
    key = 3'b101;
    cyc(6);
    chk("t3_before", ppulse, 3'b000);
    cyc(1);
    chk("t3_pulse", ppulse, 3'b010);
    cyc(2);
    key = 3'b111;
    cyc(10);
    chk_int("t3_pulse_count", pp1_cnt, 1);
    chk("t3_released", pressed, 3'b000);

    // 4. simultaneous keys 0 and 2
    key = 3'b010;
    cyc(6);
    chk("t4_before", ppulse, 3'b000);
    cyc(1);
    chk("t4_pulse", ppulse, 3'b101);
    chk("t4_pressed", pressed, 3'b101);
    key = 3'b111;
    cyc(10);
    chk("t4_released", pressed, 3'b000);

    // 5. reset during PRESS_WAIT of key 0
    key = 3'b110;
    cyc(4);
    rst = 1'b1;
    cyc(2);
    chk("t5_in_reset", ppulse, 3'b000);
    chk("t5_in_reset_lvl", pressed, 3'b000);
    rst = 1'b0;
    cyc(6);
    chk("t5_before", ppulse, 3'b000);
    cyc(1);
    chk("t5_pulse", ppulse, 3'b001);

    // 6. keep holding key 0 for 30 cycles past the press pulse
    pp0_cnt = 1;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (ppulse[0]) pp0_cnt++;
      if (i == 10) chk("t6_first_repeat", ppulse, AR ? 3'b001 : 3'b000);
      if (i == 12) chk("t6_gap", ppulse, 3'b000);
    end
    chk_int("t6_pulse_count", pp0_cnt, AR ? 7 : 1);
    key = 3'b111;
    cyc(10);
    chk("t6_released", pressed, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
